// File: rtl/reloj_config_ctrl.sv
// Button-driven time/alarm configuration sequencer for the clock counter.
// Drives the counter load interface and alarm target, and gates ALARM into a silenceable buzzer.
//
// state  | meaning
// RUN    | normal run, edit fields track the live time
// SET_HH | editing time hours
// SET_MM | editing time minutes
// LOAD   | one-cycle load strobe to the counter
// ALM_HH | editing alarm hours
// ALM_MM | editing alarm minutes
module reloj_config_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1500,
  parameter int unsigned ALM_H_DEF   = 6,
  parameter int unsigned ALM_M_DEF   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       ack_i,
  input  logic [5:0] horas_i,
  input  logic [5:0] minutos_i,
  input  logic       alarm_i,
  output logic [5:0] ihoras_o,
  output logic [5:0] iminutos_o,
  output logic       set_hora_o,
  output logic [5:0] thoras_o,
  output logic [5:0] tminutos_o,
  output logic [5:0] edit_h_o,
  output logic [5:0] edit_m_o,
  output logic [2:0] state_o,
  output logic       alm_en_o,
  output logic       buzzer_o
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_HH = 3'd1,
    SET_MM = 3'd2,
    LOAD   = 3'd3,
    ALM_HH = 3'd4,
    ALM_MM = 3'd5
  } state_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  state_t        state_q;
  logic [TW-1:0] tmr_q;
  logic [5:0]    ihoras_q, iminutos_q, thoras_q, tminutos_q, edit_h_q, edit_m_q;
  logic          set_hora_q, alm_en_q, silenced_q, buzzer_q;
  logic          hh_field;

  assign hh_field = (state_q == SET_HH) || (state_q == ALM_HH);

  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] top,
                                          input logic up);
    if (up) return (v == top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      tmr_q      <= '0;
      ihoras_q   <= 6'd0;
      iminutos_q <= 6'd0;
      set_hora_q <= 1'b0;
      thoras_q   <= 6'(ALM_H_DEF);
      tminutos_q <= 6'(ALM_M_DEF);
      edit_h_q   <= 6'd0;
      edit_m_q   <= 6'd0;
      alm_en_q   <= 1'b1;
      silenced_q <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      set_hora_q <= 1'b0;
      buzzer_q   <= alarm_i & alm_en_q & ~silenced_q;
      // Silence lasts only until the counter drops the alarm flag.
      if (!alarm_i)                silenced_q <= 1'b0;
      else if (ack_i && buzzer_q)  silenced_q <= 1'b1;
      if (ack_i && !buzzer_q)      alm_en_q   <= ~alm_en_q;

      case (state_q)
        RUN: begin
          edit_h_q <= horas_i;
          edit_m_q <= minutos_i;
          if (mode_i) begin
            state_q <= SET_HH;
            tmr_q   <= TMR_LOAD;
          end
        end
        LOAD: begin
          state_q  <= ALM_HH;
          edit_h_q <= thoras_q;
          edit_m_q <= tminutos_q;
          tmr_q    <= TMR_LOAD;
        end
        SET_HH, SET_MM, ALM_HH, ALM_MM: begin
          if (mode_i) begin
            tmr_q <= TMR_LOAD;
            case (state_q)
              SET_HH: state_q <= SET_MM;
              SET_MM: begin
                state_q    <= LOAD;
                ihoras_q   <= edit_h_q;
                iminutos_q <= edit_m_q;
                set_hora_q <= 1'b1;
              end
              ALM_HH: state_q <= ALM_MM;
              default: begin
                state_q    <= RUN;
                thoras_q   <= edit_h_q;
                tminutos_q <= edit_m_q;
              end
            endcase
          end else if (up_i || down_i) begin
            tmr_q <= TMR_LOAD;
            if (up_i ^ down_i) begin
              if (hh_field) edit_h_q <= step_mod(edit_h_q, 6'd23, up_i);
              else          edit_m_q <= step_mod(edit_m_q, 6'd59, up_i);
            end
          end else if (tmr_q == '0) begin
            state_q <= RUN;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign ihoras_o   = ihoras_q;
  assign iminutos_o = iminutos_q;
  assign set_hora_o = set_hora_q;
  assign thoras_o   = thoras_q;
  assign tminutos_o = tminutos_q;
  assign edit_h_o   = edit_h_q;
  assign edit_m_o   = edit_m_q;
  assign state_o    = state_q;
  assign alm_en_o   = alm_en_q;
  assign buzzer_o   = buzzer_q;

endmodule
